// File: rtl/sw_pkg.sv
// Shared types and frame-geometry helpers for the K x K sliding-window generator.
// Build option: SW_ZERO_PAD_EN selects "same" zero padding, with PAD = (K-1)/2.
// Without it, PAD = 0 and only fully-interior ("valid") windows are produced.
package sw_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sw_state_t;

`ifdef SW_ZERO_PAD_EN
  localparam bit SW_PAD_EN = 1'b1;
`else
  localparam bit SW_PAD_EN = 1'b0;
`endif

  function automatic int sw_pad(input int k);
    return SW_PAD_EN ? (k - 1) / 2 : 0;
  endfunction

  function automatic int sw_pw(input int w, input int k);
    return w + 2 * sw_pad(k);
  endfunction

  function automatic int sw_ph(input int h, input int k);
    return h + 2 * sw_pad(k);
  endfunction

  function automatic int sw_ow(input int w, input int k, input int s);
    return (sw_pw(w, k) - k) / s + 1;
  endfunction

  function automatic int sw_oh(input int h, input int k, input int s);
    return (sw_ph(h, k) - k) / s + 1;
  endfunction

  function automatic int sw_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Flat element index of window row r, column c.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/sw_line_buffer.sv
// K-1 line buffers organised as per-column vertical shift registers.
// A write at column col pushes the new sample into row 0 and moves each
// older sample one row down, so dout row j holds the pixel j+1 rows above.
module sw_line_buffer #(
  parameter int SW    = 8,
  parameter int ROWS  = 2,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     col,
  input  logic [SW-1:0]     din,
  output logic [ROWS*SW-1:0] dout
);

  logic [SW-1:0] mem [ROWS][DEPTH];

  // Read the column at the scan position before this step's write lands.
  always_comb begin
    dout = '0;
    for (int j = 0; j < ROWS; j++) dout[j*SW +: SW] = mem[j][col];
  end

  // Shift the column down by one row and insert the new sample on top.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0][col] <= din;
      for (int j = 1; j < ROWS; j++) mem[j][col] <= mem[j-1][col];
    end
  end

endmodule

// File: rtl/sliding_window_kxk.sv
// K x K sliding-window generator with stride, packed channels, internal
// border padding and valid/ready on both sides.
// Build option: SW_ZERO_PAD_EN enables internal zero padding of (K-1)/2.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | walking the padded frame, one step per cycle when allowed
// DRAIN | scan finished, waiting for the last window to leave
// DONE  | one-cycle done pulse
module sliding_window_kxk
  import sw_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH*DATA_W-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K*K*CH*DATA_W-1:0]   win_out
);

  localparam int PW = sw_pw(IMG_W, K);
  localparam int PH = sw_ph(IMG_H, K);
  localparam int CW = $clog2(sw_max(PW, PH));
  localparam int LW = $clog2(PW);
  localparam int SW = CH * DATA_W;

  sw_state_t state, state_nx;
  logic [CW-1:0] prow, pcol, oy, ox;
  logic is_pad, slot_free, step, last_pos, emit;
  logic [SW-1:0] pix;
  logic [(K-1)*SW-1:0] lb_flat;
  logic [K*K-1:0][SW-1:0] win_sr, win_nx, win_q;

`ifdef SW_ZERO_PAD_EN
  localparam int PAD = sw_pad(K);
  assign is_pad = (prow < CW'(PAD)) || (prow >= CW'(PAD + IMG_H)) ||
                  (pcol < CW'(PAD)) || (pcol >= CW'(PAD + IMG_W));
`else
  assign is_pad = 1'b0;
`endif

  assign slot_free = !out_valid || out_ready;
  assign last_pos  = (prow == CW'(PH - 1)) && (pcol == CW'(PW - 1));
  assign pix       = is_pad ? '0 : in_data;
  assign oy        = prow - CW'(K - 1);
  assign ox        = pcol - CW'(K - 1);
  assign emit      = step && (prow >= CW'(K - 1)) && (pcol >= CW'(K - 1)) &&
                     ((int'(oy) % STRIDE) == 0) && ((int'(ox) % STRIDE) == 0);
  assign win_out   = win_q;

  sw_line_buffer #(
    .SW   (SW),
    .ROWS (K - 1),
    .DEPTH(PW),
    .AW   (LW)
  ) u_line_buffer (
    .clk (clk),
    .we  (step),
    .col (pcol[LW-1:0]),
    .din (pix),
    .dout(lb_flat)
  );

  // Next state, input handshake and step qualification.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    step     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        in_ready = !is_pad && slot_free;
        step     = slot_free && (is_pad || in_valid);
        if (step && last_pos) state_nx = DRAIN;
      end
      DRAIN: if (!out_valid || out_ready) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Padded-frame scan position; wraps to the origin after the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prow <= '0;
      pcol <= '0;
    end else if (step) begin
      if (pcol == CW'(PW - 1)) begin
        pcol <= '0;
        prow <= (prow == CW'(PH - 1)) ? '0 : prow + 1'b1;
      end else begin
        pcol <= pcol + 1'b1;
      end
    end
  end

  // Window shifted left one column; new right column = line buffer + pixel.
  always_comb begin
    win_nx = win_sr;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K - 1; c++)
        win_nx[win_idx(r, c, K)] = win_sr[win_idx(r, c + 1, K)];
    for (int r = 0; r < K - 1; r++)
      win_nx[win_idx(r, K - 1, K)] = lb_flat[(K-2-r)*SW +: SW];
    win_nx[win_idx(K - 1, K - 1, K)] = pix;
  end

  // Window shift register advances on every step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       win_sr <= '0;
    else if (step) win_sr <= win_nx;
  end

  // Output slot: load on emit, clear on accept, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      win_q     <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      win_q     <= win_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sliding_window_kxk.sv
// Directed bench for sliding_window_kxk. Three instances share one stimulus
// path selected by sel: 0 = K3/S1 4x4, 1 = K3/S2 4x4, 2 = K5/S1 6x6 CH3.
module tb_sliding_window_kxk;

`ifdef SW_ZERO_PAD_EN
  localparam int PADON = 1;
`else
  localparam int PADON = 0;
`endif
  localparam int WV = 600;

  typedef int nine_t [9];

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [23:0] in_data;
  int sel;

  always #5 clk = ~clk;

  logic start0, start1, start2, iv0, iv1, iv2, or0, or1, or2;
  logic done0, done1, done2, ir0, ir1, ir2, ov0, ov1, ov2;
  logic [71:0]  win0, win1;
  logic [599:0] win2;

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);
  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);
  assign or0 = (sel == 0) ? out_ready : 1'b1;
  assign or1 = (sel == 1) ? out_ready : 1'b1;
  assign or2 = (sel == 2) ? out_ready : 1'b1;

  sliding_window_kxk #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .done(done0), .in_valid(iv0), .in_ready(ir0),
    .in_data(in_data[7:0]), .out_valid(ov0), .out_ready(or0), .win_out(win0));
  sliding_window_kxk #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .K(3), .STRIDE(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .done(done1), .in_valid(iv1), .in_ready(ir1),
    .in_data(in_data[7:0]), .out_valid(ov1), .out_ready(or1), .win_out(win1));
  sliding_window_kxk #(.DATA_W(8), .CH(3), .IMG_W(6), .IMG_H(6), .K(5), .STRIDE(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .done(done2), .in_valid(iv2), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(or2), .win_out(win2));

  logic m_in_ready, m_out_valid, m_done;
  logic [WV-1:0] m_win;

  always_comb begin
    m_in_ready = 1'b0; m_out_valid = 1'b0; m_done = 1'b0; m_win = '0;
    case (sel)
      0: begin m_in_ready = ir0; m_out_valid = ov0; m_done = done0; m_win = WV'(win0); end
      1: begin m_in_ready = ir1; m_out_valid = ov1; m_done = done1; m_win = WV'(win1); end
      default: begin m_in_ready = ir2; m_out_valid = ov2; m_done = done2; m_win = win2; end
    endcase
  end

  int vec = 0;
  int err = 0;
  logic [WV-1:0] got_q[$];
  int n_in, n_done, done_cyc, last_acc;

  function automatic int cfg_k(input int s);  return (s == 2) ? 5 : 3; endfunction
  function automatic int cfg_s(input int s);  return (s == 1) ? 2 : 1; endfunction
  function automatic int cfg_w(input int s);  return (s == 2) ? 6 : 4; endfunction
  function automatic int cfg_ch(input int s); return (s == 2) ? 3 : 1; endfunction
  function automatic int cfg_pad(input int s); return PADON * (cfg_k(s) - 1) / 2; endfunction
  function automatic int cfg_ow(input int s);
    return (cfg_w(s) + 2 * cfg_pad(s) - cfg_k(s)) / cfg_s(s) + 1;
  endfunction

  function automatic logic [23:0] pix_word(input int s, input int idx);
    logic [23:0] w;
    w = '0;
    w[7:0] = 8'(idx + 1);
    if (cfg_ch(s) == 3) begin
      w[15:8]  = 8'(idx + 101);
      w[23:16] = 8'(idx + 201);
    end
    return w;
  endfunction

  function automatic logic [WV-1:0] exp_win(input int s, input int oy, input int ox);
    logic [WV-1:0] v;
    logic [23:0] e;
    int k, py, px;
    k = cfg_k(s);
    v = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++) begin
        py = oy * cfg_s(s) + r - cfg_pad(s);
        px = ox * cfg_s(s) + c - cfg_pad(s);
        if (py < 0 || py >= cfg_w(s) || px < 0 || px >= cfg_w(s)) e = '0;
        else e = pix_word(s, py * cfg_w(s) + px);
        v = v | (WV'(e) << ((r * k + c) * 8 * cfg_ch(s)));
      end
    return v;
  endfunction

  function automatic logic [WV-1:0] pack9(input nine_t a);
    logic [WV-1:0] v;
    v = '0;
    for (int e = 0; e < 9; e++) v = v | (WV'(8'(a[e])) << (e * 8));
    return v;
  endfunction

  task automatic run_frame(input int s, input int in_gap, input int out_gap,
                           input int start_mid, input int hold_n);
    int hold_rem;
    bit hold_on;
    logic [WV-1:0] snap;
    sel = s; got_q.delete();
    n_in = 0; n_done = 0; done_cyc = -1; last_acc = -1;
    hold_rem = hold_n; hold_on = 0; snap = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(99) >= in_gap);
      in_data   = pix_word(s, n_in);
      out_ready = ($urandom_range(99) >= out_gap);
      start     = (start_mid != 0) && (cyc == 5);
      if (hold_rem > 0 && (hold_on || m_out_valid)) begin
        hold_on = 1; out_ready = 1'b0;
      end
      #1;
      if (hold_on && hold_rem > 0) begin
        vec++;
        if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0) begin
          err++;
          $display("FAIL stall_hold: out_valid=%b in_ready=%b, expected 1/0", m_out_valid, m_in_ready);
        end
        if (hold_rem < hold_n) begin
          vec++;
          if (m_win !== snap) begin
            err++;
            $display("FAIL stall_win: got %h expected %h", m_win, snap);
          end
        end
        snap = m_win;
        hold_rem--;
      end
      if (in_valid && m_in_ready) n_in++;
      if (m_out_valid && out_ready) begin
        got_q.push_back(m_win);
        last_acc = cyc;
      end
      if (m_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_frame(input int s, input string name);
    int ow, nw;
    bit aligned;
    ow = cfg_ow(s);
    nw = ow * ow;
    aligned = ((cfg_w(s) + 2 * cfg_pad(s) - cfg_k(s)) % cfg_s(s)) == 0;
    vec++;
    if (got_q.size() != nw) begin
      err++;
      $display("FAIL %s window_count: got %0d expected %0d", name, got_q.size(), nw);
    end
    for (int i = 0; i < nw && i < got_q.size(); i++) begin
      vec++;
      if (got_q[i] !== exp_win(s, i / ow, i % ow)) begin
        err++;
        $display("FAIL %s win%0d: got %h expected %h", name, i, got_q[i], exp_win(s, i / ow, i % ow));
      end
    end
    vec++;
    if (n_in != cfg_w(s) * cfg_w(s)) begin
      err++;
      $display("FAIL %s input_handshakes: got %0d expected %0d", name, n_in, cfg_w(s) * cfg_w(s));
    end
    vec++;
    if (n_done != 1) begin
      err++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, n_done);
    end
    vec++;
    if (aligned ? (done_cyc != last_acc + 1) : (done_cyc <= last_acc)) begin
      err++;
      $display("FAIL %s done_timing: done at %0d, last accept at %0d", name, done_cyc, last_acc);
    end
  endtask

  task automatic test_reset();
    sel = 0; start = 0; in_valid = 0; out_ready = 1; in_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (ir0 !== 1'b0 || ov0 !== 1'b0 || done0 !== 1'b0) begin
      err++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b done=%b expected 000", ir0, ov0, done0);
    end
    vec++;
    if (win0 !== 72'd0) begin err++; $display("FAIL reset_win0: got %h expected 0", win0); end
    vec++;
    if (win2 !== 600'd0 || ov2 !== 1'b0) begin
      err++;
      $display("FAIL reset_u2: out_valid=%b win=%h expected zero", ov2, win2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    nine_t a, b;
`ifdef SW_ZERO_PAD_EN
    a = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    b = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
`else
    a = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    b = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
`endif
    run_frame(0, 0, 0, 0, 0);
    check_frame(0, "k3s1");
    vec++;
    if (got_q.size() == 0 || got_q[0] !== pack9(a)) begin
      err++;
      $display("FAIL k3s1_first: got %h expected %h", (got_q.size() > 0) ? got_q[0] : '0, pack9(a));
    end
    vec++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== pack9(b)) begin
      err++;
      $display("FAIL k3s1_last: expected %h", pack9(b));
    end
  endtask

  task automatic test_stride();
    nine_t a;
    int idx;
`ifdef SW_ZERO_PAD_EN
    a = '{0, 0, 0, 2, 3, 4, 6, 7, 8};
    idx = 1;
`else
    a = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    idx = 0;
`endif
    run_frame(1, 0, 0, 0, 0);
    check_frame(1, "k3s2");
    vec++;
    if (got_q.size() <= idx || got_q[idx] !== pack9(a)) begin
      err++;
      $display("FAIL k3s2_window%0d: expected %h", idx, pack9(a));
    end
  endtask

  task automatic test_channels();
    logic [WV-1:0] w0;
    logic [23:0] centre;
`ifdef SW_ZERO_PAD_EN
    centre = 24'hC96501;
`else
    centre = 24'hD7730F;
`endif
    run_frame(2, 0, 0, 0, 0);
    check_frame(2, "k5ch3");
    w0 = (got_q.size() > 0) ? got_q[0] : '0;
    vec++;
    if (w0[12*24 +: 24] !== centre) begin
      err++;
      $display("FAIL k5ch3_centre: got %h expected %h", w0[12*24 +: 24], centre);
    end
  endtask

  task automatic test_backpressure();
    run_frame(0, 0, 0, 0, 5);
    check_frame(0, "hold5");
  endtask

  task automatic test_random_gaps();
    run_frame(0, 30, 30, 0, 0);
    check_frame(0, "gaps_k3s1");
    run_frame(2, 25, 40, 0, 0);
    check_frame(2, "gaps_k5ch3");
  endtask

  task automatic test_start_ignored();
    run_frame(1, 20, 20, 1, 0);
    check_frame(1, "start_in_run");
  endtask

  task automatic test_abort();
    int got_done;
    sel = 0; n_in = 0; got_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && n_in < 7; cyc++) begin
      in_data = pix_word(0, n_in);
      #1;
      if (m_in_ready) n_in++;
      @(negedge clk);
    end
    vec++;
    if (n_in != 7) begin err++; $display("FAIL abort_feed: got %0d pixels expected 7", n_in); end
    rst = 1'b1;
    #1;
    vec++;
    if (ir0 !== 1'b0 || ov0 !== 1'b0 || done0 !== 1'b0 || win0 !== 72'd0) begin
      err++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b done=%b win=%h expected all 0", ir0, ov0, done0, win0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done0) got_done++;
    end
    vec++;
    if (got_done != 0) begin err++; $display("FAIL abort_done: got %0d pulses expected 0", got_done); end
    run_frame(0, 10, 10, 0, 0);
    check_frame(0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stride();
    test_channels();
    test_backpressure();
    test_random_gaps();
    test_start_ignored();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
